// File: rtl/inst_mem_loader.sv
`default_nettype none
// ============================================================================
// Module      : inst_mem_loader
// Description : Byte-stream boot loader for the instruction memory.
//               Accepts a frame of  LEN_LO, LEN_HI, 4*N data bytes, CSUM.
//               LEN is the 16-bit little-endian word count N. Data bytes are
//               packed little-endian into 32-bit words and written to
//               consecutive word addresses starting at 0. CSUM must equal the
//               XOR of every earlier frame byte, including both LEN bytes.
//               The core is held in reset until an image loads cleanly.
// Ports       : sys_clk_i     system clock, rising edge
//               sys_rst_i     synchronous active-high reset
//               start_i       begin a load (ignored while busy)
//               rx_data_i     stream byte
//               rx_valid_i    stream byte valid
//               rx_ready_o    loader takes the byte this cycle
//               mem_we_o      inst_mem write strobe (one cycle per word)
//               mem_addr_o    inst_mem word address
//               mem_wdata_o   inst_mem write data
//               core_rst_n_o  core reset, 0 holds the core in reset
//               busy_o        load in progress
//               done_o        image loaded, checksum good
//               err_o         load failed (oversize length or bad checksum)
//               word_cnt_o    words written in the current/last load
// Revision    : 1.0 - initial release
// ============================================================================
module inst_mem_loader #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  sys_clk_i,
  input  logic                  sys_rst_i,
  input  logic                  start_i,
  input  logic [7:0]            rx_data_i,
  input  logic                  rx_valid_i,
  output logic                  rx_ready_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [31:0]           mem_wdata_o,
  output logic                  core_rst_n_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [ADDR_WIDTH:0]   word_cnt_o
);

  // Capacity in words, held in 17 bits so it can be compared against any
  // 16-bit length value.
  localparam logic [16:0]         CAPACITY = 17'd1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] WCNT_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] WCNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_LO = 3'd1,
    ST_LEN_HI = 3'd2,
    ST_DATA   = 3'd3,
    ST_CSUM   = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERROR  = 3'd6
  } state_e;

  state_e                state_q,      state_d;
  logic [7:0]            len_lo_q,     len_lo_d;
  logic [15:0]           words_left_q, words_left_d;
  logic [7:0]            csum_q,       csum_d;
  logic [23:0]           asm_q,        asm_d;
  logic [1:0]            byte_idx_q,   byte_idx_d;
  logic                  mem_we_q,     mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q,   mem_addr_d;
  logic [31:0]           mem_wdata_q,  mem_wdata_d;
  logic [ADDR_WIDTH:0]   word_cnt_q,   word_cnt_d;

  logic        accept;
  logic [15:0] len_full;

  always_comb begin
    state_d      = state_q;
    len_lo_d     = len_lo_q;
    words_left_d = words_left_q;
    csum_d       = csum_q;
    asm_d        = asm_q;
    byte_idx_d   = byte_idx_q;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    word_cnt_d   = word_cnt_q;
    rx_ready_o   = 1'b0;
    busy_o       = 1'b0;
    done_o       = 1'b0;
    err_o        = 1'b0;
    core_rst_n_o = 1'b0;
    len_full     = {rx_data_i, len_lo_q};

    // The write strobe is one cycle behind the 4th byte; the count advances
    // at the end of that write cycle so mem_addr reflects the old count.
    if (mem_we_q && (word_cnt_q != WCNT_MAX)) begin
      word_cnt_d = word_cnt_q + WCNT_ONE;
    end

    // Ready depends on state only, so it is valid before the byte arrives.
    rx_ready_o = (state_q == ST_LEN_LO) || (state_q == ST_LEN_HI) ||
                 (state_q == ST_DATA)   || (state_q == ST_CSUM);
    accept     = rx_valid_i && rx_ready_o;

    unique case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        done_o       = (state_q == ST_DONE);
        err_o        = (state_q == ST_ERROR);
        core_rst_n_o = (state_q == ST_DONE);
        if (start_i) begin
          state_d    = ST_LEN_LO;
          word_cnt_d = '0;
          csum_d     = 8'h00;
          byte_idx_d = 2'd0;
        end
      end

      ST_LEN_LO: begin
        busy_o = 1'b1;
        if (accept) begin
          len_lo_d = rx_data_i;
          csum_d   = csum_q ^ rx_data_i;
          state_d  = ST_LEN_HI;
        end
      end

      ST_LEN_HI: begin
        busy_o = 1'b1;
        if (accept) begin
          csum_d       = csum_q ^ rx_data_i;
          words_left_d = len_full;
          byte_idx_d   = 2'd0;
          if (len_full == 16'd0) begin
            state_d = ST_CSUM;
          end else if ({1'b0, len_full} > CAPACITY) begin
            state_d = ST_ERROR;
          end else begin
            state_d = ST_DATA;
          end
        end
      end

      ST_DATA: begin
        busy_o = 1'b1;
        if (accept) begin
          csum_d     = csum_q ^ rx_data_i;
          byte_idx_d = byte_idx_q + 2'd1;
          unique case (byte_idx_q)
            2'd0: asm_d[7:0]   = rx_data_i;
            2'd1: asm_d[15:8]  = rx_data_i;
            2'd2: asm_d[23:16] = rx_data_i;
            default: begin
              mem_we_d     = 1'b1;
              mem_addr_d   = word_cnt_q[ADDR_WIDTH-1:0];
              mem_wdata_d  = {rx_data_i, asm_q};
              words_left_d = words_left_q - 16'd1;
              if (words_left_q == 16'd1) begin
                state_d = ST_CSUM;
              end
            end
          endcase
        end
      end

      ST_CSUM: begin
        busy_o = 1'b1;
        if (accept) begin
          state_d = (rx_data_i == csum_q) ? ST_DONE : ST_ERROR;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      state_q      <= ST_IDLE;
      len_lo_q     <= 8'h00;
      words_left_q <= 16'd0;
      csum_q       <= 8'h00;
      asm_q        <= 24'd0;
      byte_idx_q   <= 2'd0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= 32'd0;
      word_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      len_lo_q     <= len_lo_d;
      words_left_q <= words_left_d;
      csum_q       <= csum_d;
      asm_q        <= asm_d;
      byte_idx_q   <= byte_idx_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      word_cnt_q   <= word_cnt_d;
    end
  end

  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign word_cnt_o  = word_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_inst_mem_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_inst_mem_loader
// Description : Self-checking bench for inst_mem_loader (ADDR_WIDTH = 4).
//               Expected memory writes are queued as frame bytes are driven
//               and popped by a monitor whenever the loader strobes mem_we.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_mem_loader;

  localparam int AW  = 4;
  localparam int CAP = 1 << AW;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic          rx_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          core_rst_n;
  logic          busy;
  logic          done;
  logic          err;
  logic [AW:0]   word_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int writes_seen = 0;

  wr_t        exp_q[$];
  logic [7:0] frame_q[$];
  logic [31:0] words_q[$];

  inst_mem_loader #(.ADDR_WIDTH(AW)) dut (
    .sys_clk_i   (clk),
    .sys_rst_i   (rst),
    .start_i     (start),
    .rx_data_i   (rx_data),
    .rx_valid_i  (rx_valid),
    .rx_ready_o  (rx_ready),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .core_rst_n_o(core_rst_n),
    .busy_o      (busy),
    .done_o      (done),
    .err_o       (err),
    .word_cnt_o  (word_cnt)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: every write strobe must match the oldest expectation.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      wr_t e;
      writes_seen++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got addr=%0h data=%08h, expected no write", mem_addr, mem_wdata);
      end else begin
        e = exp_q.pop_front();
        if (mem_addr !== e.addr || mem_wdata !== e.data) begin
          n_fail++;
          $display("FAIL write_data: got addr=%0h data=%08h, expected addr=%0h data=%08h",
                   mem_addr, mem_wdata, e.addr, e.data);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drive one byte and hold it until the loader takes it. Starts and ends
  // at a falling edge; rx_valid is left high so callers can stream bytes.
  task automatic send_byte(input logic [7:0] b, output int stalls);
    rx_data  = b;
    rx_valid = 1'b1;
    stalls   = 0;
    while (rx_ready !== 1'b1 && stalls < 50) begin
      @(negedge clk);
      stalls++;
    end
    if (rx_ready !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL rx_ready_timeout: rx_ready=%b after %0d cycles, expected 1", rx_ready, stalls);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Build a frame from words_q; the checksum is the XOR of all prior bytes
  // unless an explicit value is supplied.
  task automatic build_frame(input int n, input bit force_csum, input logic [7:0] csum);
    logic [7:0] x;
    logic [31:0] w;
    frame_q = {};
    frame_q.push_back(n[7:0]);
    frame_q.push_back(n[15:8]);
    for (int i = 0; i < words_q.size(); i++) begin
      w = words_q[i];
      frame_q.push_back(w[7:0]);
      frame_q.push_back(w[15:8]);
      frame_q.push_back(w[23:16]);
      frame_q.push_back(w[31:24]);
    end
    x = 8'h00;
    foreach (frame_q[i]) x = x ^ frame_q[i];
    frame_q.push_back(force_csum ? csum : x);
  endtask

  // Stream frame_q; queue expected writes as each word's last byte goes out
  // and check that mem_we rises exactly one cycle after that byte.
  task automatic send_frame(input bit gaps, input bit start_mid, output int stalls_total);
    int  n, st;
    bit  last_of_word;
    wr_t e;
    n = int'({frame_q[1], frame_q[0]});
    stalls_total = 0;
    for (int i = 0; i < frame_q.size(); i++) begin
      last_of_word = (i >= 2) && (i < 2 + 4 * n) && (((i - 2) % 4) == 3);
      if (last_of_word && n <= CAP) begin
        e.addr = AW'((i - 2) / 4);
        e.data = {frame_q[i], frame_q[i-1], frame_q[i-2], frame_q[i-3]};
        exp_q.push_back(e);
      end
      start = start_mid && (i == 3);
      send_byte(frame_q[i], st);
      start = 1'b0;
      stalls_total += st;
      n_checks++;
      if (mem_we !== last_of_word) begin
        n_fail++;
        $display("FAIL we_timing: byte %0d mem_we=%b, expected %b", i, mem_we, last_of_word);
      end
      if (gaps && (i % 2 == 1)) begin
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
        @(negedge clk);
      end
    end
    rx_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx_valid = 1'b1;
    rx_data = 8'hA5;
    start = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({rx_ready, mem_we, core_rst_n, busy, done, err} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_flags: rdy/we/rstn/busy/done/err=%b, expected 000000",
               {rx_ready, mem_we, core_rst_n, busy, done, err});
    end
    n_checks++;
    if (mem_addr !== '0 || mem_wdata !== 32'd0 || word_cnt !== '0) begin
      n_fail++;
      $display("FAIL reset_values: addr=%0h wdata=%08h cnt=%0d, expected 0", mem_addr, mem_wdata, word_cnt);
    end
    start = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (rx_ready !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: rx_ready=%b busy=%b, expected 0 0", rx_ready, busy);
    end
    rx_valid = 1'b0;
  endtask

  task automatic test_load();
    int st;
    // Bytes offered while idle must be ignored.
    rx_valid = 1'b1;
    rx_data  = 8'h5A;
    repeat (3) @(negedge clk);
    rx_valid = 1'b0;
    pulse_start();
    n_checks++;
    if (busy !== 1'b1 || rx_ready !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL load_started: busy=%b rx_ready=%b done=%b, expected 1 1 0", busy, rx_ready, done);
    end
    words_q = {32'h00100013, 32'h00200093};
    build_frame(2, 1'b0, 8'h00);
    send_frame(1'b1, 1'b1, st);
    n_checks++;
    if (done !== 1'b1 || core_rst_n !== 1'b1 || busy !== 1'b0 || err !== 1'b0 || word_cnt !== 5'd2) begin
      n_fail++;
      $display("FAIL load_done: done=%b rstn=%b busy=%b err=%b cnt=%0d, expected 1 1 0 0 2",
               done, core_rst_n, busy, err, word_cnt);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL load_writes: %0d expected writes missing, expected 0", exp_q.size());
    end
  endtask

  task automatic test_bad_csum();
    int st;
    pulse_start();
    n_checks++;
    if (core_rst_n !== 1'b0 || done !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_from_done: rstn=%b done=%b busy=%b, expected 0 0 1", core_rst_n, done, busy);
    end
    words_q = {32'h00100013, 32'h00200093};
    build_frame(2, 1'b1, 8'h84);
    send_frame(1'b0, 1'b0, st);
    n_checks++;
    if (err !== 1'b1 || core_rst_n !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || word_cnt !== 5'd2) begin
      n_fail++;
      $display("FAIL bad_csum: err=%b rstn=%b done=%b busy=%b cnt=%0d, expected 1 0 0 0 2",
               err, core_rst_n, done, busy, word_cnt);
    end
  endtask

  task automatic test_oversize();
    int st, w0;
    w0 = writes_seen;
    pulse_start();
    send_byte(8'h11, st);
    send_byte(8'h00, st);
    rx_data = 8'hFF;
    repeat (6) @(negedge clk);
    rx_valid = 1'b0;
    n_checks++;
    if (err !== 1'b1 || busy !== 1'b0 || rx_ready !== 1'b0 || core_rst_n !== 1'b0) begin
      n_fail++;
      $display("FAIL oversize_state: err=%b busy=%b rx_ready=%b rstn=%b, expected 1 0 0 0",
               err, busy, rx_ready, core_rst_n);
    end
    n_checks++;
    if (writes_seen != w0) begin
      n_fail++;
      $display("FAIL oversize_writes: %0d writes, expected 0", writes_seen - w0);
    end
  endtask

  task automatic test_full_capacity();
    int st;
    pulse_start();
    words_q = {};
    for (int i = 0; i < CAP; i++) words_q.push_back($urandom);
    build_frame(CAP, 1'b0, 8'h00);
    send_frame(1'b0, 1'b0, st);
    n_checks++;
    if (done !== 1'b1 || word_cnt !== 5'(CAP) || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL full_capacity: done=%b cnt=%0d pending=%0d, expected 1 %0d 0",
               done, word_cnt, exp_q.size(), CAP);
    end
  endtask

  task automatic test_back_to_back();
    int st;
    pulse_start();
    words_q = {32'h00100013, 32'h00200093};
    build_frame(2, 1'b0, 8'h00);
    send_frame(1'b0, 1'b0, st);
    n_checks++;
    if (st != 0) begin
      n_fail++;
      $display("FAIL b2b_stalls: %0d stall cycles, expected 0", st);
    end
    n_checks++;
    if (done !== 1'b1 || word_cnt !== 5'd2 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_done: done=%b cnt=%0d pending=%0d, expected 1 2 0", done, word_cnt, exp_q.size());
    end
  endtask

  task automatic test_empty_and_abort();
    int st, w0;
    w0 = writes_seen;
    pulse_start();
    words_q = {};
    build_frame(0, 1'b0, 8'h00);
    send_frame(1'b0, 1'b0, st);
    n_checks++;
    if (done !== 1'b1 || core_rst_n !== 1'b1 || word_cnt !== 5'd0 || writes_seen != w0) begin
      n_fail++;
      $display("FAIL empty_frame: done=%b rstn=%b cnt=%0d writes=%0d, expected 1 1 0 0",
               done, core_rst_n, word_cnt, writes_seen - w0);
    end
    // Reset lands on the same edge as a word's 4th byte: no write may follow.
    pulse_start();
    send_byte(8'h02, st);
    send_byte(8'h00, st);
    send_byte(8'h13, st);
    send_byte(8'h00, st);
    send_byte(8'h10, st);
    rx_data = 8'h00;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (mem_we !== 1'b0 || busy !== 1'b0 || rx_ready !== 1'b0 || core_rst_n !== 1'b0 ||
        done !== 1'b0 || err !== 1'b0 || word_cnt !== 5'd0) begin
      n_fail++;
      $display("FAIL abort_reset: we=%b busy=%b rdy=%b rstn=%b done=%b err=%b cnt=%0d, expected all 0",
               mem_we, busy, rx_ready, core_rst_n, done, err, word_cnt);
    end
    rst = 1'b0;
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (writes_seen != w0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_idle: writes=%0d busy=%b, expected 0 0", writes_seen - w0, busy);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_load();
    test_bad_csum();
    test_oversize();
    test_full_capacity();
    test_back_to_back();
    test_empty_and_abort();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
